// File: rtl/uart_cmd_ctrl.sv
// Command-frame sequencer behind the UART receiver: SOF, OP, LEN, payload, CHK.
// Validates frames, holds accepted commands on a valid/ready handshake, reports errors.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [7:0]             cmd_op,
  output logic [7:0]             cmd_len,
  output logic [8*MAX_LEN-1:0]   cmd_payload,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(MAX_LEN + 1);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IW-1:0] IDX_MAX   = IW'(MAX_LEN);
  // cnt is 0 in the first idle cycle after a byte, so the cycle that lies
  // TIMEOUT_CYC-1 cycles after the byte sees cnt == TIMEOUT_CYC-2.
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYC - 2);

  localparam logic [1:0] ERR_LEN = 2'b00;
  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_OVR = 2'b11;

  typedef enum logic [2:0] {
    WAIT_SOF, GET_OP, GET_LEN, GET_PAY, GET_CHK, HOLD
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             op, len, chk;
  logic [8*MAX_LEN-1:0]   payload;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic                   in_frame, timeout, pay_last;
  logic                   err_now;
  logic [1:0]             err_cause;

  always_comb begin
    in_frame = (state == GET_OP) || (state == GET_LEN) ||
               (state == GET_PAY) || (state == GET_CHK);
    timeout  = in_frame && !rx_valid && (cnt == CNT_LAST);
    pay_last = (8'(idx) == len - 8'd1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_SOF;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_SOF: if (rx_valid && rx_data == SOF) state_n = GET_OP;
      GET_OP:   if (rx_valid) state_n = GET_LEN;
      GET_LEN:
        if (rx_valid) begin
          if (rx_data > MAX_LEN_B)   state_n = WAIT_SOF;
          else if (rx_data == 8'd0)  state_n = GET_CHK;
          else                       state_n = GET_PAY;
        end
      GET_PAY:  if (rx_valid && pay_last) state_n = GET_CHK;
      GET_CHK:  if (rx_valid) state_n = (rx_data == chk) ? HOLD : WAIT_SOF;
      HOLD:     if (cmd_ready) state_n = WAIT_SOF;
      default:  state_n = WAIT_SOF;
    endcase
    if (timeout) state_n = WAIT_SOF;
  end

  // Output logic
  always_comb begin
    cmd_valid = (state == HOLD);
    busy      = (state != WAIT_SOF);
    err_now   = 1'b0;
    err_cause = ERR_LEN;
    unique case (state)
      GET_LEN: if (rx_valid && rx_data > MAX_LEN_B) begin
        err_now = 1'b1; err_cause = ERR_LEN;
      end
      GET_CHK: if (rx_valid && rx_data != chk) begin
        err_now = 1'b1; err_cause = ERR_CHK;
      end
      HOLD: if (rx_valid && !cmd_ready) begin
        err_now = 1'b1; err_cause = ERR_OVR;
      end
      default: ;
    endcase
    if (timeout) begin
      err_now = 1'b1; err_cause = ERR_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      len       <= '0;
      chk       <= '0;
      payload   <= '0;
      idx       <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
      err_code  <= ERR_LEN;
    end else begin
      frame_err <= err_now;
      if (err_now) err_code <= err_cause;

      if (in_frame) cnt <= rx_valid ? '0 : cnt + CW'(1);
      else          cnt <= '0;

      if (rx_valid) begin
        unique case (state)
          WAIT_SOF: if (rx_data == SOF) begin
            payload <= '0;
            chk     <= '0;
            idx     <= '0;
          end
          GET_OP: begin
            op  <= rx_data;
            chk <= rx_data;
          end
          GET_LEN: if (rx_data <= MAX_LEN_B) begin
            len <= rx_data;
            chk <= chk ^ rx_data;
          end
          GET_PAY: begin
            for (int unsigned i = 0; i < MAX_LEN; i++)
              if (idx == i[IW-1:0]) payload[8*i +: 8] <= rx_data;
            chk <= chk ^ rx_data;
            idx <= (idx == IDX_MAX) ? idx : idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign cmd_op      = op;
  assign cmd_len     = len;
  assign cmd_payload = payload;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames with literal checks,
// then randomized frames checked every cycle against a frame-level model.
module tb_uart_cmd_ctrl;

  localparam int MAXL = 8;
  localparam int TMO  = 20;
  localparam logic [7:0] SOFB = 8'hA5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      rx_data = '0;
  logic            rx_valid = 1'b0;
  logic            cmd_ready = 1'b0;
  logic            cmd_valid;
  logic [7:0]      cmd_op, cmd_len;
  logic [8*MAXL-1:0] cmd_payload;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            busy;
  logic            rand_rdy = 1'b0;

  int ncmp = 0;
  int nbad = 0;

  uart_cmd_ctrl #(.SOF(SOFB), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_payload(cmd_payload), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: collects the bytes after SOF and judges the frame by its
  // length and by the XOR of everything after SOF being zero.
  logic [7:0]  q[$];
  bit          m_active = 0, m_hold = 0, e_err = 0;
  int          m_gap = 0;
  logic [1:0]  e_code = 2'b00;
  logic [7:0]  e_op = '0, e_len = '0;
  logic [63:0] e_pay = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_hold = 0; m_gap = 0; q.delete();
      e_err = 0; e_code = 2'b00; e_op = '0; e_len = '0; e_pay = '0;
    end else begin
      e_err = 0;
      if (m_hold) begin
        if (cmd_ready) m_hold = 0;
        else if (rx_valid) begin e_err = 1; e_code = 2'b11; end
      end else if (m_active) begin
        if (rx_valid) begin
          q.push_back(rx_data);
          m_gap = 0;
          if (q.size() == 2 && q[1] > MAXL) begin
            e_err = 1; e_code = 2'b00; m_active = 0;
          end else if (q.size() >= 2 && q.size() == int'(q[1]) + 3) begin
            logic [7:0] x;
            x = '0;
            foreach (q[i]) x ^= q[i];
            if (x == 8'h00) begin
              m_hold = 1; e_op = q[0]; e_len = q[1]; e_pay = '0;
              for (int i = 0; i < int'(q[1]); i++) e_pay[8*i +: 8] = q[2+i];
            end else begin
              e_err = 1; e_code = 2'b01;
            end
            m_active = 0;
          end
        end else begin
          m_gap++;
          if (m_gap == TMO - 1) begin e_err = 1; e_code = 2'b10; m_active = 0; end
        end
      end else if (rx_valid && rx_data == SOFB) begin
        m_active = 1; m_gap = 0; q.delete();
      end
    end
  end

  always @(negedge clk) begin
    cmp("cmd_valid", 64'(cmd_valid), 64'(m_hold));
    cmp("busy", 64'(busy), 64'(m_active || m_hold));
    cmp("frame_err", 64'(frame_err), 64'(e_err));
    cmp("err_code", 64'(err_code), 64'(e_code));
    if (m_hold) begin
      cmp("cmd_op", 64'(cmd_op), 64'(e_op));
      cmp("cmd_len", 64'(cmd_len), 64'(e_len));
      cmp("cmd_payload", cmd_payload, e_pay);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
    if (rand_rdy) cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_frame_a();
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h65);
  endtask

  task automatic check_reset_values(input string tag);
    cmp({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    cmp({tag, "_err"}, 64'(frame_err), 64'd0);
    cmp({tag, "_busy"}, 64'(busy), 64'd0);
    cmp({tag, "_op"}, 64'(cmd_op), 64'd0);
    cmp({tag, "_len"}, 64'(cmd_len), 64'd0);
    cmp({tag, "_pay"}, cmd_payload, 64'd0);
    cmp({tag, "_code"}, 64'(err_code), 64'd0);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] x;
    int kind, len;

    idle(3);
    @(negedge clk);
    check_reset_values("rst");
    #2 rst_n = 1'b1;
    idle(2);

    // Valid frame with cmd_ready high
    cmd_ready = 1'b1;
    send_frame_a();
    @(negedge clk);
    cmp("a_valid", 64'(cmd_valid), 64'd1);
    cmp("a_op", 64'(cmd_op), 64'h10);
    cmp("a_len", 64'(cmd_len), 64'd2);
    cmp("a_pay", cmd_payload, 64'h4433);
    cmp("a_err", 64'(frame_err), 64'd0);
    idle(2);

    // Zero-length frame
    send(8'hA5); send(8'h7E); send(8'h00); send(8'h7E);
    @(negedge clk);
    cmp("z_valid", 64'(cmd_valid), 64'd1);
    cmp("z_op", 64'(cmd_op), 64'h7E);
    cmp("z_len", 64'(cmd_len), 64'd0);
    cmp("z_pay", cmd_payload, 64'd0);
    idle(2);

    // Checksum error, then a good frame
    send(8'hA5); send(8'h10); send(8'h02); send(8'h33); send(8'h44); send(8'h66);
    @(negedge clk);
    cmp("c_err", 64'(frame_err), 64'd1);
    cmp("c_code", 64'(err_code), 64'd1);
    cmp("c_valid", 64'(cmd_valid), 64'd0);
    idle(1);
    @(negedge clk);
    cmp("c_err_gone", 64'(frame_err), 64'd0);
    send_frame_a();
    @(negedge clk);
    cmp("c_next_valid", 64'(cmd_valid), 64'd1);
    idle(2);

    // Bad length
    send(8'hA5); send(8'h10); send(8'h09);
    @(negedge clk);
    cmp("l_err", 64'(frame_err), 64'd1);
    cmp("l_code", 64'(err_code), 64'd0);
    cmp("l_busy", 64'(busy), 64'd0);
    idle(2);

    // Timeout: frame_err visible 20 cycles after the last byte
    send(8'hA5); send(8'h10);
    idle(18);
    @(negedge clk);
    cmp("t_early", 64'(frame_err), 64'd0);
    idle(1);
    @(negedge clk);
    cmp("t_err", 64'(frame_err), 64'd1);
    cmp("t_code", 64'(err_code), 64'd2);
    idle(2);

    // Byte landing on the timeout cycle wins
    send(8'hA5); send(8'h10);
    idle(18);
    send(8'h02);
    @(negedge clk);
    cmp("t2_err", 64'(frame_err), 64'd0);
    cmp("t2_busy", 64'(busy), 64'd1);
    send(8'h33); send(8'h44); send(8'h65);
    @(negedge clk);
    cmp("t2_valid", 64'(cmd_valid), 64'd1);
    idle(2);

    // Backpressure, noise and overrun
    cmd_ready = 1'b0;
    send(8'h00); send(8'hFF);
    send_frame_a();
    idle(3);
    @(negedge clk);
    cmp("b_valid", 64'(cmd_valid), 64'd1);
    cmp("b_err", 64'(frame_err), 64'd0);
    send(8'h11);
    @(negedge clk);
    cmp("o_err", 64'(frame_err), 64'd1);
    cmp("o_code", 64'(err_code), 64'd3);
    cmp("o_valid", 64'(cmd_valid), 64'd1);
    cmp("o_op", 64'(cmd_op), 64'h10);
    cmp("o_pay", cmd_payload, 64'h4433);
    cmd_ready = 1'b1;
    step();
    @(negedge clk);
    cmp("h_valid", 64'(cmd_valid), 64'd0);
    idle(2);

    // Reset mid-payload
    send(8'hA5); send(8'h20); send(8'h04); send(8'h01); send(8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid_rst");
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic
    rand_rdy = 1'b1;
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      fr.delete();
      if (kind == 0) begin
        fr.push_back(8'($urandom_range(0, 255)));
      end else begin
        len = (kind == 1) ? $urandom_range(MAXL + 1, 255) : $urandom_range(0, MAXL);
        fr.push_back(SOFB);
        fr.push_back(8'($urandom_range(0, 255)));
        fr.push_back(8'(len));
        if (kind != 1) begin
          for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
          x = '0;
          for (int i = 1; i < fr.size(); i++) x ^= fr[i];
          if (kind == 2) x ^= 8'($urandom_range(1, 255));
          fr.push_back(x);
        end
      end
      foreach (fr[i]) begin
        if ($urandom_range(0, 29) == 0) idle($urandom_range(17, 21));
        else idle($urandom_range(0, 3));
        send(fr[i]);
      end
      idle($urandom_range(0, 4));
    end
    rand_rdy = 1'b0;
    cmd_ready = 1'b1;
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level controller that sits after the UART receive path. It consumes the stream of received bytes and sequences them into command frames of the form SOF, OP, LEN, payload, CHK. It validates each frame and presents accepted commands to downstream logic over a valid/ready handshake. It also reports malformed frames, inter-byte timeouts and overruns.

## Interface

Parameters:
- SOF, 8'hA5: start-of-frame byte.
- MAX_LEN, 8: maximum payload bytes per frame (1..15).
- TIMEOUT_CYC, 100000: maximum clk cycles allowed between bytes inside a frame (2 ms at 50 MHz).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- rx_data, in, 8: received byte; qualified by rx_valid.
- rx_valid, in, 1: single-cycle strobe, one per received byte.
- cmd_valid, out, 1: a validated command is presented.
- cmd_ready, in, 1: downstream accepts the command.
- cmd_op, out, 8: command opcode.
- cmd_len, out, 8: payload length, 0..MAX_LEN.
- cmd_payload, out, 8*MAX_LEN: payload byte i is at bits [8i+7:8i]; unused bytes are zero.
- frame_err, out, 1: one-cycle pulse when a frame is discarded.
- err_code, out, 2: cause of the last error. 00 = bad length, 01 = checksum, 10 = timeout, 11 = overrun. Updated in the frame_err cycle and held afterwards.
- busy, out, 1: high whenever the state is not WAIT_SOF.

## Operation

- States: WAIT_SOF, GET_OP, GET_LEN, GET_PAY, GET_CHK, HOLD.
- WAIT_SOF:
  - rx_valid with rx_data==SOF: clear payload, running checksum, byte index and timeout counter; go to GET_OP.
  - Any other byte: dropped silently, no error.
- GET_OP: the byte is latched as op. Checksum becomes op. Go to GET_LEN.
- GET_LEN:
  - LEN>MAX_LEN: frame_err with err_code 00; go to WAIT_SOF.
  - LEN==0: go to GET_CHK.
  - Otherwise: go to GET_PAY.
  - In all accepted cases, checksum ^= LEN.
- GET_PAY: each byte is stored at the current index, checksum ^= byte, and the index increments. After byte LEN-1, go to GET_CHK.
- GET_CHK:
  - Byte == checksum (XOR of OP, LEN and all payload bytes): go to HOLD.
  - Mismatch: frame_err with err_code 01; go to WAIT_SOF.
- HOLD:
  - cmd_valid=1. cmd_op, cmd_len and cmd_payload stay stable until cmd_valid && cmd_ready.
  - On the handshake, go to WAIT_SOF.
  - rx_valid in HOLD without cmd_ready: the byte is dropped and frame_err pulses with err_code 11. The held command is unaffected.
  - rx_valid in the handshake cycle: the byte is dropped with no error.
- Timeout:
  - The counter runs in GET_OP through GET_CHK and resets on every rx_valid.
  - When it reaches TIMEOUT_CYC-1 with no rx_valid in that cycle: frame_err with err_code 10; go to WAIT_SOF.
  - rx_valid in the same cycle as the timeout wins; the byte is processed normally.
  - The counter does not run in WAIT_SOF or HOLD.
- The timeout counter width is $clog2(TIMEOUT_CYC). The byte index saturates at MAX_LEN. All checksum arithmetic is 8-bit XOR with no carries.

## Timing

- Reset values:
  - state = WAIT_SOF.
  - cmd_valid, frame_err, busy = 0.
  - cmd_op, cmd_len, cmd_payload = 0.
  - err_code = 00.
- Reset mid-frame or mid-HOLD discards everything immediately, asynchronously.
- cmd_valid rises on the clk edge after the rx_valid cycle carrying a correct CHK byte, giving 1-cycle latency.
- cmd_valid falls on the edge after the handshake cycle.
- Back-to-back commands: a new SOF is accepted on the cycle after the handshake.
- frame_err is registered. It is high for exactly the one cycle after the offending rx_valid or timeout cycle.
- At most one byte is processed per cycle. rx_valid is never assumed to be held high for more than 1 cycle.

## Test plan

- Valid frame A5 10 02 33 44 65, cmd_ready=1 -> one cycle after the 65 strobe: cmd_valid=1, cmd_op=10, cmd_len=2, cmd_payload[15:0]=4433, upper bytes 0; no frame_err.
- Zero-length frame A5 7E 00 7E -> cmd_valid, cmd_op=7E, cmd_len=0, cmd_payload=0.
- Checksum error A5 10 02 33 44 66 -> frame_err for 1 cycle with err_code=01 and no cmd_valid. A following correct frame is accepted.
- Bad length A5 10 09 (MAX_LEN=8) -> frame_err with err_code=00 right after the 09 strobe; busy=0 next cycle.
- Timeout: with TIMEOUT_CYC=20, send A5 10 and then idle -> frame_err with err_code=10, 20 cycles after the 10 strobe. Repeat with a byte landing exactly on cycle 19 -> no error.
- Backpressure and noise:
  - Send 00 FF, then a valid frame, with cmd_ready=0 -> no error for the leading bytes; cmd_valid held stable.
  - Inject byte 11 during HOLD -> frame_err with err_code=11 while the command is unchanged.
  - Raise cmd_ready -> handshake; cmd_valid=0 next cycle.
  - Assert rst_n low mid-payload -> all outputs are at their reset values.
